mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between an I-cache (read only)
// and a D-cache (read/write). Request fields are latched at grant; all outputs are registered.
module mem_arbiter #(
   parameter int ADDR_WIDTH       = 17,
   parameter int LEN              = 32,
   parameter int ENTRY_INDEX_SIZE = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  i_vis_signal,
   input  logic [ADDR_WIDTH-1:0]       i_vis_addr,
   input  logic [1:0]                  d_vis_signal,
   input  logic [ADDR_WIDTH-1:0]       d_vis_addr,
   input  logic [LEN-1:0]              d_written_data,
   input  logic [2:0]                  d_data_type,
   input  logic [ENTRY_INDEX_SIZE:0]   d_write_length,
   input  logic [LEN-1:0]              mem_data,
   input  logic [1:0]                  mem_status,
   output logic [1:0]                  mem_vis_signal,
   output logic [ADDR_WIDTH-1:0]       mem_vis_addr,
   output logic [LEN-1:0]              mem_written_data,
   output logic [2:0]                  mem_data_type,
   output logic [ENTRY_INDEX_SIZE:0]   mem_write_length,
   output logic [1:0]                  i_status,
   output logic [LEN-1:0]              i_data,
   output logic [1:0]                  d_status,
   output logic [LEN-1:0]              d_data
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;
   localparam logic [1:0] REQ_RD  = 2'b01;
   localparam logic [1:0] REQ_WR  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_GRANT_I, S_GRANT_D, S_RELEASE} state_t;

   state_t                      state_q, state_d;
   logic                        last_d_q, last_d_d;   // 1: last tie went to D
   logic [1:0]                  mem_vis_signal_q, mem_vis_signal_d;
   logic [ADDR_WIDTH-1:0]       mem_vis_addr_q, mem_vis_addr_d;
   logic [LEN-1:0]              mem_written_data_q, mem_written_data_d;
   logic [2:0]                  mem_data_type_q, mem_data_type_d;
   logic [ENTRY_INDEX_SIZE:0]   mem_write_length_q, mem_write_length_d;
   logic [1:0]                  i_status_q, i_status_d;
   logic [LEN-1:0]              i_data_q, i_data_d;
   logic [1:0]                  d_status_q, d_status_d;
   logic [LEN-1:0]              d_data_q, d_data_d;

   logic i_pend, d_pend, mem_done, done_i, done_d;

   always_comb begin
      i_pend   = (i_vis_signal == REQ_RD);
      d_pend   = (d_vis_signal == REQ_RD) || (d_vis_signal == REQ_WR);
      mem_done = (mem_status == ST_DONE);
      done_i   = (state_q == S_GRANT_I) && mem_done;
      done_d   = (state_q == S_GRANT_D) && mem_done;

      state_d            = state_q;
      last_d_d           = last_d_q;
      mem_vis_signal_d   = mem_vis_signal_q;
      mem_vis_addr_d     = mem_vis_addr_q;
      mem_written_data_d = mem_written_data_q;
      mem_data_type_d    = mem_data_type_q;
      mem_write_length_d = mem_write_length_q;
      i_data_d           = i_data_q;
      d_data_d           = d_data_q;

      // A requester stays busy while it owns the port, even if it drops its request.
      i_status_d = done_i ? ST_DONE : ((state_q == S_GRANT_I) || i_pend) ? ST_BUSY : ST_IDLE;
      d_status_d = done_d ? ST_DONE : ((state_q == S_GRANT_D) || d_pend) ? ST_BUSY : ST_IDLE;

      case (state_q)
         S_IDLE: begin
            if (i_pend && (!d_pend || last_d_q)) begin
               state_d            = S_GRANT_I;
               mem_vis_signal_d   = i_vis_signal;
               mem_vis_addr_d     = i_vis_addr;
               mem_written_data_d = '0;
               mem_data_type_d    = '0;
               mem_write_length_d = '0;
               if (d_pend) last_d_d = 1'b0;
            end else if (d_pend) begin
               state_d            = S_GRANT_D;
               mem_vis_signal_d   = d_vis_signal;
               mem_vis_addr_d     = d_vis_addr;
               mem_written_data_d = d_written_data;
               mem_data_type_d    = d_data_type;
               mem_write_length_d = d_write_length;
               if (i_pend) last_d_d = 1'b1;
            end
         end
         S_GRANT_I: begin
            if (mem_done) begin
               state_d          = S_RELEASE;
               mem_vis_signal_d = 2'b00;
               if (mem_vis_signal_q == REQ_RD) i_data_d = mem_data;
            end
         end
         S_GRANT_D: begin
            if (mem_done) begin
               state_d          = S_RELEASE;
               mem_vis_signal_d = 2'b00;
               if (mem_vis_signal_q == REQ_RD) d_data_d = mem_data;
            end
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q            <= S_IDLE;
         last_d_q           <= 1'b1;
         mem_vis_signal_q   <= '0;
         mem_vis_addr_q     <= '0;
         mem_written_data_q <= '0;
         mem_data_type_q    <= '0;
         mem_write_length_q <= '0;
         i_status_q         <= '0;
         i_data_q           <= '0;
         d_status_q         <= '0;
         d_data_q           <= '0;
      end else begin
         state_q            <= state_d;
         last_d_q           <= last_d_d;
         mem_vis_signal_q   <= mem_vis_signal_d;
         mem_vis_addr_q     <= mem_vis_addr_d;
         mem_written_data_q <= mem_written_data_d;
         mem_data_type_q    <= mem_data_type_d;
         mem_write_length_q <= mem_write_length_d;
         i_status_q         <= i_status_d;
         i_data_q           <= i_data_d;
         d_status_q         <= d_status_d;
         d_data_q           <= d_data_d;
      end
   end

   assign mem_vis_signal   = mem_vis_signal_q;
   assign mem_vis_addr     = mem_vis_addr_q;
   assign mem_written_data = mem_written_data_q;
   assign mem_data_type    = mem_data_type_q;
   assign mem_write_length = mem_write_length_q;
   assign i_status         = i_status_q;
   assign i_data           = i_data_q;
   assign d_status         = d_status_q;
   assign d_data           = d_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

   localparam int AW = 17;
   localparam int LW = 32;
   localparam int EW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    i_vis_signal = '0;
   logic [AW-1:0] i_vis_addr = '0;
   logic [1:0]    d_vis_signal = '0;
   logic [AW-1:0] d_vis_addr = '0;
   logic [LW-1:0] d_written_data = '0;
   logic [2:0]    d_data_type = '0;
   logic [EW-1:0] d_write_length = '0;
   logic [LW-1:0] mem_data = '0;
   logic [1:0]    mem_status = '0;
   logic [1:0]    mem_vis_signal;
   logic [AW-1:0] mem_vis_addr;
   logic [LW-1:0] mem_written_data;
   logic [2:0]    mem_data_type;
   logic [EW-1:0] mem_write_length;
   logic [1:0]    i_status;
   logic [LW-1:0] i_data;
   logic [1:0]    d_status;
   logic [LW-1:0] d_data;

   mem_arbiter #(.ADDR_WIDTH(AW), .LEN(LW), .ENTRY_INDEX_SIZE(EW-1)) dut (
      .clk(clk), .rst(rst),
      .i_vis_signal(i_vis_signal), .i_vis_addr(i_vis_addr),
      .d_vis_signal(d_vis_signal), .d_vis_addr(d_vis_addr),
      .d_written_data(d_written_data), .d_data_type(d_data_type),
      .d_write_length(d_write_length),
      .mem_data(mem_data), .mem_status(mem_status),
      .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
      .mem_written_data(mem_written_data), .mem_data_type(mem_data_type),
      .mem_write_length(mem_write_length),
      .i_status(i_status), .i_data(i_data),
      .d_status(d_status), .d_data(d_data)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: who owns the memory port (0 none, 1 I, 2 D), the quiet cycle after a
   // completion, the last tie winner, and the expected value of every output.
   int            owner;
   int            gap;
   bit            tie_last_d;
   logic [1:0]    e_sig;
   logic [AW-1:0] e_addr;
   logic [LW-1:0] e_wd;
   logic [2:0]    e_type;
   logic [EW-1:0] e_len;
   logic [1:0]    e_i_status, e_d_status;
   logic [LW-1:0] e_i_data, e_d_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      owner = 0; gap = 0; tie_last_d = 1'b1;
      e_sig = '0; e_addr = '0; e_wd = '0; e_type = '0; e_len = '0;
      e_i_status = '0; e_d_status = '0; e_i_data = '0; e_d_data = '0;
   endtask

   task automatic model_edge();
      bit ip, dp, di, dd, pick_i;
      ip = (i_vis_signal == 2'b01);
      dp = (d_vis_signal == 2'b01) || (d_vis_signal == 2'b10);
      di = (owner == 1) && (mem_status == 2'b10);
      dd = (owner == 2) && (mem_status == 2'b10);
      e_i_status = di ? 2'b10 : ((owner == 1) || ip) ? 2'b01 : 2'b00;
      e_d_status = dd ? 2'b10 : ((owner == 2) || dp) ? 2'b01 : 2'b00;
      if (di || dd) begin
         if (e_sig == 2'b01) begin
            if (di) e_i_data = mem_data;
            else    e_d_data = mem_data;
         end
         e_sig = 2'b00;
         owner = 0;
         gap   = 1;
      end else if (owner == 0) begin
         if (gap > 0) gap--;
         else if (ip || dp) begin
            if (ip && dp) begin
               pick_i     = tie_last_d;
               tie_last_d = !pick_i;
            end else pick_i = ip;
            if (pick_i) begin
               owner = 1; e_sig = i_vis_signal; e_addr = i_vis_addr;
               e_wd = '0; e_type = '0; e_len = '0;
            end else begin
               owner = 2; e_sig = d_vis_signal; e_addr = d_vis_addr;
               e_wd = d_written_data; e_type = d_data_type; e_len = d_write_length;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("mem_vis_signal",   32'(mem_vis_signal),   32'(e_sig));
      chk("mem_vis_addr",     32'(mem_vis_addr),     32'(e_addr));
      chk("mem_written_data", mem_written_data,      e_wd);
      chk("mem_data_type",    32'(mem_data_type),    32'(e_type));
      chk("mem_write_length", 32'(mem_write_length), 32'(e_len));
      chk("i_status",         32'(i_status),         32'(e_i_status));
      chk("i_data",           i_data,                e_i_data);
      chk("d_status",         32'(d_status),         32'(e_d_status));
      chk("d_data",           d_data,                e_d_data);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_edge();
      else     model_reset();
      #1;
      check_all();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sig"},  32'(mem_vis_signal), 32'h0);
      chk({tag, "_addr"}, 32'(mem_vis_addr),   32'h0);
      chk({tag, "_wd"},   mem_written_data,    32'h0);
      chk({tag, "_type"}, 32'(mem_data_type),  32'h0);
      chk({tag, "_len"},  32'(mem_write_length), 32'h0);
      chk({tag, "_ist"},  32'(i_status),       32'h0);
      chk({tag, "_idat"}, i_data,              32'h0);
      chk({tag, "_dst"},  32'(d_status),       32'h0);
      chk({tag, "_ddat"}, d_data,              32'h0);
   endtask

   initial begin
      model_reset();
      tick(); tick();
      chk_all_zero("reset");
      #3 rst = 1'b1;
      tick();

      // Lone I read
      i_vis_signal = 2'b01; i_vis_addr = 17'h00010;
      tick();
      chk("s1_grant_sig", 32'(mem_vis_signal), 32'h1);
      chk("s1_grant_addr", 32'(mem_vis_addr), 32'h10);
      chk("s1_busy", 32'(i_status), 32'h1);
      tick(); tick();
      mem_status = 2'b10; mem_data = 32'hDEADBEEF;
      tick();
      chk("s1_done_status", 32'(i_status), 32'h2);
      chk("s1_done_data", i_data, 32'hDEADBEEF);
      chk("s1_done_sig", 32'(mem_vis_signal), 32'h0);
      i_vis_signal = 2'b00; mem_status = 2'b00;
      tick();
      chk("s1_after_status", 32'(i_status), 32'h0);
      chk("s1_hold_data", i_data, 32'hDEADBEEF);
      tick(); tick();

      // Tie after reset: I wins first, then D wins the next tie
      i_vis_signal = 2'b01; i_vis_addr = 17'h00020;
      d_vis_signal = 2'b01; d_vis_addr = 17'h00030;
      tick();
      chk("s2_tie1_addr", 32'(mem_vis_addr), 32'h20);
      chk("s2_d_wait", 32'(d_status), 32'h1);
      tick();
      mem_status = 2'b10; mem_data = 32'h11111111;
      tick();
      chk("s2_i_done", 32'(i_status), 32'h2);
      mem_status = 2'b00;
      tick();
      chk("s2_release_sig", 32'(mem_vis_signal), 32'h0);
      chk("s2_i_rebusy", 32'(i_status), 32'h1);
      tick();
      chk("s2_tie2_sig", 32'(mem_vis_signal), 32'h1);
      chk("s2_tie2_addr", 32'(mem_vis_addr), 32'h30);
      mem_status = 2'b10; mem_data = 32'h22222222;
      tick();
      chk("s2_d_done", 32'(d_status), 32'h2);
      chk("s2_d_data", d_data, 32'h22222222);
      d_vis_signal = 2'b00; mem_status = 2'b00;
      tick(); tick();
      chk("s2_i_again", 32'(mem_vis_addr), 32'h20);
      mem_status = 2'b10; mem_data = 32'h33333333;
      tick();
      chk("s2_i_data2", i_data, 32'h33333333);
      i_vis_signal = 2'b00; mem_status = 2'b00;
      tick(); tick();

      // D write, inputs changed mid-grant, mem done outside grant ignored
      d_vis_signal = 2'b10; d_vis_addr = 17'h00400; d_written_data = 32'h12345678;
      d_data_type = 3'd2; d_write_length = 4'd1;
      tick();
      d_vis_addr = 17'h00ABC; d_written_data = 32'h0BADF00D; d_data_type = 3'd5;
      d_write_length = 4'd7;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("s3_hold_sig", 32'(mem_vis_signal), 32'h2);
         chk("s3_hold_addr", 32'(mem_vis_addr), 32'h400);
         chk("s3_hold_wd", mem_written_data, 32'h12345678);
         chk("s3_hold_type", 32'(mem_data_type), 32'h2);
         chk("s3_hold_len", 32'(mem_write_length), 32'h1);
      end
      mem_status = 2'b10; mem_data = 32'hCAFEF00D;
      tick();
      chk("s3_done", 32'(d_status), 32'h2);
      chk("s3_d_data_kept", d_data, 32'h22222222);
      d_vis_signal = 2'b00;
      tick(); tick();
      chk("s3_stray_done", 32'(d_status), 32'h0);
      mem_status = 2'b00;

      // Illegal codes
      i_vis_signal = 2'b10; d_vis_signal = 2'b11;
      tick(); tick();
      i_vis_signal = 2'b11;
      tick();
      chk("s4_sig", 32'(mem_vis_signal), 32'h0);
      chk("s4_ist", 32'(i_status), 32'h0);
      chk("s4_dst", 32'(d_status), 32'h0);
      i_vis_signal = 2'b00; d_vis_signal = 2'b00;
      tick();

      // Reset during GRANT_D
      d_vis_signal = 2'b01; d_vis_addr = 17'h00055;
      tick(); tick();
      chk("s5_granted", 32'(mem_vis_addr), 32'h55);
      #3 rst = 1'b0;
      #1 chk_all_zero("s5_async");
      model_reset();
      mem_status = 2'b10;
      tick(); tick();
      mem_status = 2'b00;
      #3 rst = 1'b1;
      tick();
      chk("s5_regrant", 32'(mem_vis_signal), 32'h1);
      chk("s5_rebusy", 32'(d_status), 32'h1);
      mem_status = 2'b10; mem_data = 32'h5A5A5A5A;
      tick();
      d_vis_signal = 2'b00; mem_status = 2'b00;
      tick(); tick();

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            i_vis_signal = 2'($urandom_range(0, 3));
            i_vis_addr   = AW'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            d_vis_signal   = 2'($urandom_range(0, 3));
            d_vis_addr     = AW'($urandom);
            d_written_data = $urandom;
            d_data_type    = 3'($urandom);
            d_write_length = EW'($urandom);
         end
         mem_status = ($urandom_range(0, 9) < 3) ? 2'b10 : 2'($urandom_range(0, 1));
         mem_data   = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
